// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: start, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Define UART_RX_MAJORITY_EN for 3-sample majority bit decisions; otherwise a single sample at P/2 is used.
module uart_rx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESC_W    = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [PRESC_W-1:0]    Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [PRESC_W-1:0] C_ONE      = PRESC_W'(1);
   localparam logic [PRESC_W-1:0] C_P8       = PRESC_W'(8);
   localparam logic [PRESC_W-1:0] C_P16      = PRESC_W'(16);
   localparam logic [PRESC_W-1:0] C_P32      = PRESC_W'(32);
   localparam logic [BW-1:0]      C_LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0]      C_BIT_ONE  = BW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [PRESC_W-1:0]    r_presc;
   logic                  r_par_en;
   logic                  r_par_typ;
   logic [PRESC_W-1:0]    r_edge_cnt;
   logic [BW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_bit;
   logic                  r_par_bad;

   logic                  w_start;
   logic [PRESC_W-1:0]    w_presc_in;
   logic [PRESC_W-1:0]    w_half;
   logic                  w_last;
   logic                  w_decide;
   logic                  w_bit;
   logic                  w_dv;
   logic                  w_pe;
   logic                  w_se;

   assign w_start    = (r_state == S_IDLE) && !RX_IN;
   assign w_presc_in = ((Prescale == C_P16) || (Prescale == C_P32)) ? Prescale : C_P8;
   assign w_half     = r_presc >> 1;
   assign w_last     = (r_edge_cnt == (r_presc - C_ONE));

`ifdef UART_RX_MAJORITY_EN
   logic r_s0;
   logic r_s1;

   // Two early samples are held; the third is the live line at P/2+1, where the vote is taken.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_s0 <= 1'b1;
         r_s1 <= 1'b1;
      end else begin
         if (r_edge_cnt == (w_half - C_ONE)) r_s0 <= RX_IN;
         if (r_edge_cnt == w_half)           r_s1 <= RX_IN;
      end
   end

   assign w_decide = (r_edge_cnt == (w_half + C_ONE));
   assign w_bit    = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);
`else
   assign w_decide = (r_edge_cnt == w_half);
   assign w_bit    = RX_IN;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dv        = 1'b0;
      w_pe        = 1'b0;
      w_se        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!RX_IN) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_decide && w_bit) w_state_nxt = S_IDLE;
            else if (w_last)       w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_last && (r_bit_cnt == C_LAST_BIT))
               w_state_nxt = r_par_en ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (w_last) w_state_nxt = S_STOP;
         end
         S_STOP: begin
            if (w_last) begin
               w_state_nxt = S_IDLE;
               w_se        = !r_bit;
               w_pe        = r_par_bad;
               w_dv        = r_bit && !r_par_bad;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // The detecting cycle is edge 0, so the counter enters START already at 1.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_edge_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_edge_cnt <= RX_IN ? '0 : C_ONE;
      end else if (w_last || (w_state_nxt == S_IDLE)) begin
         r_edge_cnt <= '0;
      end else begin
         r_edge_cnt <= r_edge_cnt + C_ONE;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_presc   <= '0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_bit     <= 1'b0;
         r_par_bad <= 1'b0;
      end else begin
         if (w_start) begin
            r_presc   <= w_presc_in;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_bit_cnt <= '0;
            r_par_bad <= 1'b0;
         end
         if (w_decide && (r_state != S_IDLE)) r_bit <= w_bit;
         if ((r_state == S_DATA) && w_decide)
            r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
         if ((r_state == S_DATA) && w_last)
            r_bit_cnt <= r_bit_cnt + C_BIT_ONE;
         if ((r_state == S_PARITY) && w_decide)
            r_par_bad <= w_bit ^ (^r_shift) ^ r_par_typ;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         P_DATA     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= w_dv;
         par_err    <= w_pe;
         stp_err    <= w_se;
         if (w_dv) P_DATA <= r_shift;
      end
   end

endmodule
